xpb_table_gen: RTL and testbench
================================

// Module: xpb_table_gen
// PURPOSE
//  Run-time programmable XPB reduction table: entry i = (i * BASE) mod MOD, for i in 0..DEPTH-1.
//  Generated on chip by iterative modular addition after a start pulse.
//  Served to NUM_RD independent read channels with registered, 1-cycle read latency.
//  Replaces fixed per-modulus constant tables in the modular-square reduction path.
// PARAMETERS
//  WORD_BITS  1024  width of MOD, BASE and table entries
//  IDX_BITS   5     table index width; DEPTH = 2**IDX_BITS
//  NUM_RD     1     number of independent read channels
// PORTS
//  clk      in   1                    clock
//  reset    in   1                    asynchronous, active-high reset
//  start    in   1                    1-cycle pulse: begin generation
//  mod_in   in   WORD_BITS            modulus N, sampled on accepted start
//  base_in  in   WORD_BITS            BASE (= 2^k mod N), sampled on accepted start
//  busy     out  1                    generation in progress
//  ready    out  1                    table valid for current N/BASE
//  err      out  1                    1-cycle pulse: start rejected
//  rd_idx   in   NUM_RD*IDX_BITS      per-channel index, channel c at [c*IDX_BITS +: IDX_BITS]
//  rd_data  out  NUM_RD*WORD_BITS     per-channel entry, registered
//  rd_valid out  NUM_RD               per-channel valid, registered
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, ready=0, err=0, rd_data=0, rd_valid=0; table storage not cleared.
//  States:
//   - IDLE: wait for start.
//   - GEN: write one entry per cycle.
//   - DONE: ready=1; table served.
//  Start acceptance:
//   - Accepted only in IDLE or DONE.
//   - Ignored in GEN: no err, generation continues unchanged.
//   - Rejected if mod_in==0 or base_in>=mod_in: err=1 for one cycle; state, ready and table unchanged.
//  Accepted start at edge T0:
//   - Latch N and BASE; table[0] <= 0; acc <= 0; ready <= 0; busy <= 1; state <= GEN.
//  GEN, edge Tj (j = 1..DEPTH-1):
//   - s = acc + BASE, computed WORD_BITS+1 wide.
//   - t = (s >= N) ? s - N : s.
//   - table[j] <= t; acc <= t.
//  At edge T(DEPTH-1): state <= DONE, busy <= 0, ready <= 1.
//  Generation therefore takes DEPTH-1 cycles after acceptance. Invariant: acc < N.
//  Restart from DONE: ready drops at the accepting edge; the old table is overwritten.
//  Reads, per channel, every cycle:
//   - rd_data <= ready ? table[rd_idx] : 0.
//   - rd_valid <= ready.
//   - Read latency is 1 cycle; any index is legal because depth is a power of two.
//  Reset mid-GEN: abort immediately; ready=0 until a new accepted start completes.
// STRUCTURE
//  Package xpb_pkg: state enum {IDLE, GEN, DONE}; localparam DEPTH = 1 << IDX_BITS.
//  Sub-module xpb_mod_add: combinational (a + b) mod n for a, b < n, WORD_BITS wide.
//  Storage: DEPTH x WORD_BITS register array, one write port, NUM_RD read ports.
//  Write index is a counter that wraps at DEPTH-1 into the DONE transition.
// TESTING
//  1. WORD_BITS=16, IDX_BITS=5. start with N=97, BASE=40.
//     -> busy for 31 cycles, then ready.
//     -> idx 0,1,2,3,4,31 read as 0,40,80,23,63,76.
//  2. Same configuration, start with BASE=97, N=97.
//     -> err pulses once; ready and busy stay 0.
//     -> reads return 0 with rd_valid=0.
//  3. Second start pulse mid-GEN (cycle 10) with different N.
//     -> ignored; final table matches the first N/BASE.
//  4. Reset asserted at GEN cycle 15.
//     -> busy=0, ready=0 immediately.
//     -> new start N=97, BASE=40 completes as in case 1.
//  5. NUM_RD=3 with indices 31, 0, 3 in the same cycle after ready.
//     -> next cycle rd_data = 76, 0, 23; all rd_valid=1.
//  6. WORD_BITS=1024, random 1024-bit N and BASE<N.
//     -> all 32 entries match the golden model i*BASE mod N; restart from DONE with a new N.
//     -> ready low during regeneration, new table correct.

Source files
------------

// File: rtl/xpb_pkg.sv
// Shared definitions for the XPB reduction-table generator: controller states
// and the default table geometry.
package xpb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    DONE = 2'd2
  } xpb_state_e;

  localparam int IDX_BITS_DEF = 5;
  localparam int DEPTH        = 1 << IDX_BITS_DEF;

  // Table depth for a given index width.
  function automatic int depth_of(input int idx_bits);
    return 1 << idx_bits;
  endfunction

endpackage

// File: rtl/xpb_mod_add.sv
// Combinational modular addition (a + b) mod n, valid for a, b < n.
// One guarded subtraction suffices because a + b < 2n.
module xpb_mod_add #(
  parameter int WORD_BITS = 1024
) (
  input  logic [WORD_BITS-1:0] i_a,
  input  logic [WORD_BITS-1:0] i_b,
  input  logic [WORD_BITS-1:0] i_n,
  output logic [WORD_BITS-1:0] o_sum
);

  logic [WORD_BITS:0] w_s;
  logic [WORD_BITS:0] w_n_ext;

  assign w_n_ext = {1'b0, i_n};
  assign w_s     = {1'b0, i_a} + {1'b0, i_b};
  assign o_sum   = (w_s >= w_n_ext) ? WORD_BITS'(w_s - w_n_ext) : w_s[WORD_BITS-1:0];

endmodule

// File: rtl/xpb_table_gen.sv
// Run-time programmable XPB table: entry i = (i * BASE) mod N, built one entry
// per cycle by repeated modular addition, served on NUM_RD registered read ports.
module xpb_table_gen
  import xpb_pkg::*;
#(
  parameter int WORD_BITS = 1024,
  parameter int IDX_BITS  = IDX_BITS_DEF,
  parameter int NUM_RD    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [WORD_BITS-1:0]          mod_in,
  input  logic [WORD_BITS-1:0]          base_in,
  output logic                          busy,
  output logic                          ready,
  output logic                          err,
  input  logic [NUM_RD*IDX_BITS-1:0]    rd_idx,
  output logic [NUM_RD*WORD_BITS-1:0]   rd_data,
  output logic [NUM_RD-1:0]             rd_valid
);

  localparam int                  L_DEPTH = depth_of(IDX_BITS);
  localparam logic [IDX_BITS-1:0] L_LAST  = IDX_BITS'(L_DEPTH - 1);
  localparam logic [IDX_BITS-1:0] L_ONE   = IDX_BITS'(1);

  xpb_state_e               r_state;
  xpb_state_e               w_state_nxt;
  logic [IDX_BITS-1:0]      r_wr_idx;
  logic [WORD_BITS-1:0]     r_n;
  logic [WORD_BITS-1:0]     r_base;
  logic [WORD_BITS-1:0]     r_acc;
  logic [WORD_BITS-1:0]     r_table [L_DEPTH];
  logic                     r_err;
  logic [NUM_RD*WORD_BITS-1:0] r_rd_data;
  logic [NUM_RD-1:0]        r_rd_valid;

  logic                     w_start_ok;
  logic                     w_accept;
  logic                     w_reject;
  logic [WORD_BITS-1:0]     w_next_acc;

  assign w_start_ok = (mod_in != '0) && (base_in < mod_in);

  // Start is only considered outside GEN; a start during GEN is silently dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          if (w_start_ok) begin
            w_accept    = 1'b1;
            w_state_nxt = GEN;
          end else begin
            w_reject    = 1'b1;
          end
        end
      end
      GEN: begin
        if (r_wr_idx == L_LAST) begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_err    <= 1'b0;
      r_wr_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_reject;
      if (w_accept) begin
        r_wr_idx <= L_ONE;
      end else if (r_state == GEN) begin
        r_wr_idx <= r_wr_idx + L_ONE;
      end
    end
  end

  xpb_mod_add #(
    .WORD_BITS (WORD_BITS)
  ) u_mod_add (
    .i_a   (r_acc),
    .i_b   (r_base),
    .i_n   (r_n),
    .o_sum (w_next_acc)
  );

  // Operands and table storage carry no reset; ready gates every read.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_n        <= mod_in;
      r_base     <= base_in;
      r_acc      <= '0;
      r_table[0] <= '0;
    end else if (r_state == GEN) begin
      r_acc             <= w_next_acc;
      r_table[r_wr_idx] <= w_next_acc;
    end
  end

  assign busy  = (r_state == GEN);
  assign ready = (r_state == DONE);
  assign err   = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= '0;
    end else begin
      for (int c = 0; c < NUM_RD; c++) begin
        r_rd_valid[c] <= ready;
        r_rd_data[c*WORD_BITS +: WORD_BITS] <=
          ready ? r_table[rd_idx[c*IDX_BITS +: IDX_BITS]] : '0;
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_xpb_table_gen.sv
// Bench for xpb_table_gen: directed small-modulus cases plus random 1024-bit
// tables, with reads scored against an i*BASE mod N reference.
module tb_xpb_table_gen;

  localparam int W  = 1024;
  localparam int IB = 5;
  localparam int NR = 3;
  localparam int D  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [W-1:0]      mod_in;
  logic [W-1:0]      base_in;
  logic              busy;
  logic              ready;
  logic              err;
  logic [NR*IB-1:0]  rd_idx;
  logic [NR*W-1:0]   rd_data;
  logic [NR-1:0]     rd_valid;

  xpb_table_gen #(
    .WORD_BITS (W),
    .IDX_BITS  (IB),
    .NUM_RD    (NR)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mod_in   (mod_in),
    .base_in  (base_in),
    .busy     (busy),
    .ready    (ready),
    .err      (err),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  // clock / cycle counter
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic [W-1:0] m_tab [D];
  logic         m_ready = 1'b0;

  // scoreboard queues
  int              exp_cyc_q[$];
  logic [NR*W-1:0] exp_q[$];
  logic [NR-1:0]   exp_vld_q[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [W-1:0] ref_entry(input int i, input logic [W-1:0] n,
                                              input logic [W-1:0] b);
    logic [W+7:0] p;
    p = (W+8)'(i) * {8'b0, b};
    return W'(p % {8'b0, n});
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int k = 0; k < W/32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic model_load(input logic [W-1:0] n, input logic [W-1:0] b);
    for (int i = 0; i < D; i++) m_tab[i] = ref_entry(i, n, b);
  endtask

  // monitor: compare registered read outputs in the cycle they are due
  always @(negedge clk) begin
    while (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
      logic [NR*W-1:0] e_d;
      logic [NR-1:0]   e_v;
      void'(exp_cyc_q.pop_front());
      e_d = exp_q.pop_front();
      e_v = exp_vld_q.pop_front();
      chk("rd_valid", W'(rd_valid), W'(e_v));
      for (int c = 0; c < NR; c++)
        chk($sformatf("rd_data[%0d]", c), rd_data[c*W +: W], e_d[c*W +: W]);
    end
  end

  // driver tasks (all inputs change #1 after a rising edge)
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd3(input int a, input int b, input int c);
    int              idx[NR];
    logic [NR*W-1:0] e_d;
    idx[0] = a; idx[1] = b; idx[2] = c;
    for (int k = 0; k < NR; k++) begin
      rd_idx[k*IB +: IB] = IB'(idx[k]);
      e_d[k*W +: W] = m_ready ? m_tab[idx[k]] : '0;
    end
    exp_cyc_q.push_back(cyc + 1);
    exp_q.push_back(e_d);
    exp_vld_q.push_back({NR{m_ready}});
    step();
  endtask

  task automatic start_reject(input logic [W-1:0] n, input logic [W-1:0] b);
    mod_in = n; base_in = b; start = 1'b1;
    step();
    start = 1'b0;
    chk("err_pulse", W'(err), W'(1'b1));
    chk("ready_after_reject", W'(ready), W'(m_ready));
    chk("busy_after_reject", W'(busy), W'(1'b0));
    step();
    chk("err_one_cycle", W'(err), W'(1'b0));
  endtask

  // Accept a start and follow generation; optionally inject an ignored start
  // at GEN cycle ign_at, or an asynchronous reset at GEN cycle rst_at.
  task automatic start_accept(input logic [W-1:0] n, input logic [W-1:0] b,
                              input int ign_at, input int rst_at);
    int cnt;
    mod_in = n; base_in = b; start = 1'b1;
    step();
    start = 1'b0;
    m_ready = 1'b0;
    model_load(n, b);
    chk("busy_at_accept", W'(busy), W'(1'b1));
    chk("ready_at_accept", W'(ready), W'(1'b0));
    cnt = 0;
    while (!ready && cnt < 100) begin
      if (cnt == ign_at) begin
        mod_in = n + W'(2); start = 1'b1;
      end
      if (cnt == rst_at) begin
        reset = 1'b1;
        #1;
        chk("busy_on_reset", W'(busy), W'(1'b0));
        chk("ready_on_reset", W'(ready), W'(1'b0));
        chk("rd_valid_on_reset", W'(rd_valid), '0);
        #1;
        reset = 1'b0;
        return;
      end
      step();
      start = 1'b0;
      cnt++;
      chk("err_quiet_in_gen", W'(err), W'(1'b0));
      if (!ready) chk("busy_in_gen", W'(busy), W'(1'b1));
    end
    chk("gen_cycles", W'(cnt), W'(D - 1));
    chk("busy_at_done", W'(busy), W'(1'b0));
    m_ready = 1'b1;
  endtask

  task automatic read_all();
    for (int i = 0; i < D; i++) rd3(i, $urandom_range(0, D-1), D - 1 - i);
  endtask

  initial begin
    logic [W-1:0] n, b;
    reset = 1'b1; start = 1'b0; mod_in = '0; base_in = '0; rd_idx = '0;
    step(); step();
    chk("rst_busy", W'(busy), W'(1'b0));
    chk("rst_ready", W'(ready), W'(1'b0));
    chk("rst_err", W'(err), W'(1'b0));
    chk("rst_rd_valid", W'(rd_valid), '0);
    chk("rst_rd_data0", rd_data[W-1:0], '0);
    reset = 1'b0;
    step();

    // rejected start from IDLE: BASE == N, then N == 0
    start_reject(W'(97), W'(97));
    start_reject('0, '0);
    rd3(0, 1, 31);

    // N=97, BASE=40
    start_accept(W'(97), W'(40), -1, -1);
    rd3(0, 1, 2);
    rd3(3, 4, 31);
    rd3(31, 0, 3);

    // rejected start from DONE keeps table and ready
    start_reject(W'(97), W'(200));
    rd3(31, 4, 3);

    // restart from DONE with a start ignored mid-GEN
    start_accept(W'(101), W'(55), 10, -1);
    read_all();

    // reset mid-GEN, then regenerate
    start_accept(W'(97), W'(40), -1, 15);
    m_ready = 1'b0;
    step();
    rd3(31, 0, 3);
    start_accept(W'(97), W'(40), -1, -1);
    rd3(31, 0, 3);

    // random full-width moduli, restarted from DONE
    for (int t = 0; t < 3; t++) begin
      n = rand_word();
      n[W-1] = 1'b1;
      b = rand_word() % n;
      start_accept(n, b, -1, -1);
      read_all();
    end

    step(); step();
    chk("scoreboard_drained", W'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
